// File: rtl/sparse_chunk_writer.sv
// Producer side of the ping-pong sparse chunk buffers: compresses dense beats into
// sparsemap + left-packed nonzero bytes. Optional stats port: define SPARSE_CHUNK_STATS_EN.
module sparse_chunk_writer #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int CNT_W          = $clog2(WR_DAT_CYC_NUM)
`ifdef SPARSE_CHUNK_STATS_EN
  , parameter int NZ_W         = $clog2(BUS_SIZE*WR_DAT_CYC_NUM) + 1
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [BUS_SIZE*8-1:0] dense_data_i,
  input  logic                  dense_valid_i,
  output logic                  dense_ready_o,
  input  logic                  abort_i,
  input  logic                  buf_release_i,
  input  logic                  buf_release_sel_i,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic                  wr_sel_o,
  output logic                  chunk_done_o,
  output logic [1:0]            buf_full_o
`ifdef SPARSE_CHUNK_STATS_EN
  , output logic [NZ_W-1:0]     chunk_nz_cnt_o
`endif
);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic [1:0]            full_q, full_d;
  logic [BUS_SIZE-1:0]   map_c;
  logic [BUS_SIZE*8-1:0] pack_c;
  logic                  accept, last_beat;

  // The buffer FSM (EMPTY / ONE_FULL / BOTH_FULL) is exactly the popcount of full_q,
  // so the flags themselves are the state register.
  assign dense_ready_o = !full_q[sel_q] && rst_ni && !abort_i;
  assign accept        = dense_valid_i && dense_ready_o;
  assign last_beat     = (cnt_q == CNT_W'(WR_DAT_CYC_NUM - 1));

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    int pos;
    map_c  = '0;
    pack_c = '0;
    pos    = 0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      if (dense_data_i[k*8 +: 8] != 8'h00) begin
        map_c[k]          = 1'b1;
        pack_c[pos*8 +: 8] = dense_data_i[k*8 +: 8];
        pos++;
      end
    end
  end

  // Release is applied before set so that set-and-release of one buffer leaves it full.
  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    full_d = full_q;
    if (buf_release_i) full_d[buf_release_sel_i] = 1'b0;
    if (abort_i) begin
      cnt_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        cnt_d         = '0;
        sel_d         = ~sel_q;
        full_d[sel_q] = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q             <= '0;
      sel_q             <= 1'b0;
      full_q            <= 2'b00;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_valid_o        <= 1'b0;
      wr_count_o        <= '0;
      wr_sel_o          <= 1'b0;
      chunk_done_o      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      full_q       <= full_d;
      wr_valid_o   <= accept;
      chunk_done_o <= accept && last_beat;
      if (accept) begin
        wr_sparsemap_o    <= map_c;
        wr_nonzero_data_o <= pack_c;
        wr_count_o        <= cnt_q;
        wr_sel_o          <= sel_q;
      end
    end
  end

  assign buf_full_o = full_q;

`ifdef SPARSE_CHUNK_STATS_EN
  logic [NZ_W-1:0] nz_beat_c, nz_acc_q;

  always_comb begin
    nz_beat_c = '0;
    for (int k = 0; k < BUS_SIZE; k++) nz_beat_c = nz_beat_c + NZ_W'(map_c[k]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nz_acc_q       <= '0;
      chunk_nz_cnt_o <= '0;
    end else if (abort_i) begin
      nz_acc_q <= '0;
    end else if (accept) begin
      if (last_beat) begin
        nz_acc_q       <= '0;
        chunk_nz_cnt_o <= nz_acc_q + nz_beat_c;
      end else begin
        nz_acc_q <= nz_acc_q + nz_beat_c;
      end
    end
  end
`endif

endmodule
